// File: rtl/axi_node_pkg.sv
// Types and constants shared by the AXI node's address-decode stages.
package axi_node_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ERR_W,
        ERR_B
    } aw_dec_state_e;

endpackage

// File: rtl/axi_aw_rule_match.sv
// Address-to-region matcher: flags every master port with at least one enabled
// region containing the address. Shared by the AW and AR decoders.
module axi_aw_rule_match #(
    parameter int N_INIT_PORT = 4,
    parameter int N_REGION    = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic [ADDR_WIDTH-1:0]                                addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] start_addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] end_addr,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region,
    output logic [N_INIT_PORT-1:0]                               match
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        match = '0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            for (int r = 0; r < N_REGION; r++) begin
                if (enable_region[r][p] &&
                    addr >= start_addr[r][p] && addr <= end_addr[r][p]) begin
                    match[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_aw_route_decoder.sv
// AW-channel router for one slave port: forwards routed bursts to a master port
// and answers decode misses locally with a DECERR write response.
module axi_aw_route_decoder
    import axi_node_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int N_REGION    = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 awvalid_i,
    input  logic [ADDR_WIDTH-1:0]                                awaddr_i,
    input  logic [ID_WIDTH-1:0]                                  awid_i,
    output logic                                                 awready_o,
    output logic [N_INIT_PORT-1:0]                               awvalid_o,
    input  logic [N_INIT_PORT-1:0]                               awready_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
    input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
    input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
    output logic [N_INIT_PORT-1:0]                               DEST_o,
    output logic                                                 push_DEST_o,
    input  logic                                                 grant_FIFO_DEST_i,
    input  logic                                                 wlast_done_i,
    output logic                                                 handle_error_o,
    input  logic                                                 wdata_error_completed_i,
    output logic                                                 bvalid_o,
    output logic [1:0]                                           bresp_o,
    output logic [ID_WIDTH-1:0]                                  bid_o,
    input  logic                                                 bready_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    aw_dec_state_e          state;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       outstanding_next;
    logic [N_INIT_PORT-1:0] region_match;
    logic [N_INIT_PORT-1:0] hit;
    logic [N_INIT_PORT-1:0] dest;
    logic                   miss;
    logic                   route_ready;
    logic                   miss_handshake;

    axi_aw_rule_match #(
        .N_INIT_PORT (N_INIT_PORT),
        .N_REGION    (N_REGION),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_rule_match (
        .addr          (awaddr_i),
        .start_addr    (START_ADDR_i),
        .end_addr      (END_ADDR_i),
        .enable_region (enable_region_i),
        .match         (region_match)
    );

    // Isolating the lowest set bit gives the lowest-index port priority on overlaps.
    assign hit    = region_match & connectivity_map_i;
    assign dest   = hit & (~hit + N_INIT_PORT'(1));
    assign miss   = (hit == '0);
    assign DEST_o = dest;

    assign route_ready    = (|(awready_i & dest)) && grant_FIFO_DEST_i;
    assign miss_handshake = (state == IDLE) && miss && awvalid_i;

    always_comb begin
        awvalid_o   = '0;
        awready_o   = 1'b0;
        push_DEST_o = 1'b0;
        if (state == IDLE) begin
            if (miss) begin
                awready_o = 1'b1;
            end else begin
                awready_o   = route_ready;
                push_DEST_o = awvalid_i && route_ready;
                if (awvalid_i && grant_FIFO_DEST_i) begin
                    awvalid_o = dest;
                end
            end
        end
    end

    always_comb begin
        outstanding_next = outstanding;
        if (push_DEST_o && !wlast_done_i) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (wlast_done_i && !push_DEST_o && outstanding != '0) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            outstanding    <= '0;
            handle_error_o <= 1'b0;
            bvalid_o       <= 1'b0;
            bresp_o        <= RESP_OKAY;
            bid_o          <= '0;
        end else begin
            outstanding <= outstanding_next;
            case (state)
                IDLE: begin
                    if (miss_handshake) begin
                        bid_o <= awid_i;
                        state <= DRAIN;
                    end
                end
                // Earlier bursts must finish their W data before the error burst is sunk.
                DRAIN: begin
                    if (outstanding_next == '0) begin
                        handle_error_o <= 1'b1;
                        state          <= ERR_W;
                    end
                end
                ERR_W: begin
                    if (wdata_error_completed_i) begin
                        handle_error_o <= 1'b0;
                        bvalid_o       <= 1'b1;
                        bresp_o        <= RESP_DECERR;
                        state          <= ERR_B;
                    end
                end
                ERR_B: begin
                    if (bready_i) begin
                        bvalid_o <= 1'b0;
                        bresp_o  <= RESP_OKAY;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_wlast_underflow: assert property (@(posedge clk) disable iff (rst)
        !(wlast_done_i && outstanding == '0));

endmodule

// File: tb/tb_axi_aw_route_decoder.sv
// Self-checking bench for axi_aw_route_decoder: vector table, error-burst
// sequences, and randomized routing against a first-match region model.
module tb_axi_aw_route_decoder;
    import axi_node_pkg::*;

    localparam int NP = 4;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int FD = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          awvalid_i;
    logic [AW-1:0]                 awaddr_i;
    logic [IW-1:0]                 awid_i;
    logic                          awready_o;
    logic [NP-1:0]                 awvalid_o;
    logic [NP-1:0]                 awready_i;
    logic [NR-1:0][NP-1:0][AW-1:0] start_addr;
    logic [NR-1:0][NP-1:0][AW-1:0] end_addr;
    logic [NR-1:0][NP-1:0]         en_region;
    logic [NP-1:0]                 conn;
    logic [NP-1:0]                 dest_o;
    logic                          push_dest_o;
    logic                          grant;
    logic                          wlast_done;
    logic                          handle_error_o;
    logic                          werr_done;
    logic                          bvalid_o;
    logic [1:0]                    bresp_o;
    logic [IW-1:0]                 bid_o;
    logic                          bready;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    axi_aw_route_decoder #(
        .N_INIT_PORT (NP),
        .N_REGION    (NR),
        .ADDR_WIDTH  (AW),
        .ID_WIDTH    (IW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .awvalid_i               (awvalid_i),
        .awaddr_i                (awaddr_i),
        .awid_i                  (awid_i),
        .awready_o               (awready_o),
        .awvalid_o               (awvalid_o),
        .awready_i               (awready_i),
        .START_ADDR_i            (start_addr),
        .END_ADDR_i              (end_addr),
        .enable_region_i         (en_region),
        .connectivity_map_i      (conn),
        .DEST_o                  (dest_o),
        .push_DEST_o             (push_dest_o),
        .grant_FIFO_DEST_i       (grant),
        .wlast_done_i            (wlast_done),
        .handle_error_o          (handle_error_o),
        .wdata_error_completed_i (werr_done),
        .bvalid_o                (bvalid_o),
        .bresp_o                 (bresp_o),
        .bid_o                   (bid_o),
        .bready_i                (bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rdy;
        logic        grant;
        logic [3:0]  conn;
        bit          ovl;
        logic [3:0]  exp_vld;
        logic        exp_rdy;
        logic        exp_push;
        logic [3:0]  exp_dest;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port p owns [p*256MB, p*256MB + 256MB - 1]; ovl adds port 1 region 1 at 0x0800_0000.
    task automatic set_map(input bit ovl);
        for (int p = 0; p < NP; p++) begin
            start_addr[0][p] = 32'(p) * 32'h1000_0000;
            end_addr[0][p]   = start_addr[0][p] + 32'h0FFF_FFFF;
            en_region[0][p]  = 1'b1;
            start_addr[1][p] = '0;
            end_addr[1][p]   = '0;
            en_region[1][p]  = 1'b0;
        end
        if (ovl) begin
            start_addr[1][1] = 32'h0800_0000;
            end_addr[1][1]   = 32'h0FFF_FFFF;
            en_region[1][1]  = 1'b1;
        end
    endtask

    // First matching port in ascending order wins.
    function automatic logic [3:0] model_dest(input logic [31:0] a);
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < NR; r++)
                if (conn[p] && en_region[r][p] &&
                    a >= start_addr[r][p] && a <= end_addr[r][p])
                    return 4'(1 << p);
        return 4'b0000;
    endfunction

    // Miss handshake, drain of n_wlast earlier bursts, W sink, held DECERR, return to IDLE.
    task automatic miss_seq(input string tag, input logic [31:0] addr, input logic [3:0] id,
                            input int n_wlast);
        awaddr_i  = addr;
        awid_i    = id;
        awready_i = '1;
        grant     = 1'b1;
        awvalid_i = 1'b1;
        #1;
        check({tag, "_miss_awready"}, 32'(awready_o), 32'd1);
        check({tag, "_miss_awvalid"}, 32'(awvalid_o), 32'd0);
        check({tag, "_miss_push"}, 32'(push_dest_o), 32'd0);
        tick();
        awaddr_i = '0;
        awid_i   = '0;
        #1;
        check({tag, "_drain_awready"}, 32'(awready_o), 32'd0);
        check({tag, "_drain_awvalid"}, 32'(awvalid_o), 32'd0);
        if (n_wlast == 0) begin
            check({tag, "_drain_handle"}, 32'(handle_error_o), 32'd0);
            tick();
        end
        for (int i = 0; i < n_wlast; i++) begin
            check({tag, "_drain_handle"}, 32'(handle_error_o), 32'd0);
            wlast_done = 1'b1;
            tick();
            wlast_done = 1'b0;
        end
        check({tag, "_errw_handle"}, 32'(handle_error_o), 32'd1);
        check({tag, "_errw_awready"}, 32'(awready_o), 32'd0);
        check({tag, "_errw_push"}, 32'(push_dest_o), 32'd0);
        tick();
        check({tag, "_errw_hold"}, 32'(handle_error_o), 32'd1);
        check({tag, "_errw_bvalid"}, 32'(bvalid_o), 32'd0);
        werr_done = 1'b1;
        tick();
        werr_done = 1'b0;
        check({tag, "_errb_handle"}, 32'(handle_error_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_errb_bvalid"}, 32'(bvalid_o), 32'd1);
            check({tag, "_errb_bresp"}, 32'(bresp_o), 32'(RESP_DECERR));
            check({tag, "_errb_bid"}, 32'(bid_o), 32'(id));
            check({tag, "_errb_awready"}, 32'(awready_o), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_idle_bvalid"}, 32'(bvalid_o), 32'd0);
        check({tag, "_idle_awvalid"}, 32'(awvalid_o), 32'h1);
        check({tag, "_idle_push"}, 32'(push_dest_o), 32'd1);
        awvalid_i = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_dest;
        logic       exp_rdy;
        logic [3:0] exp_vld;

        rst        = 1'b1;
        awvalid_i  = 1'b0;
        awaddr_i   = '0;
        awid_i     = '0;
        awready_i  = '0;
        conn       = 4'b1111;
        grant      = 1'b1;
        wlast_done = 1'b0;
        werr_done  = 1'b0;
        bready     = 1'b0;
        set_map(1'b0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_handle", 32'(handle_error_o), 32'd0);
        check("rst_bvalid", 32'(bvalid_o), 32'd0);
        check("rst_bresp", 32'(bresp_o), 32'd0);
        check("rst_bid", 32'(bid_o), 32'd0);
        check("rst_awvalid", 32'(awvalid_o), 32'd0);
        check("rst_awready", 32'(awready_o), 32'd0);
        check("rst_push", 32'(push_dest_o), 32'd0);

        //             addr          rdy      gnt   conn     ovl  vld      rdy   push  dest
        vecs.push_back('{32'h2000_0040, 4'b0100, 1'b1, 4'b1111, 0, 4'b0100, 1'b1, 1'b1, 4'b0100});
        vecs.push_back('{32'h2000_0040, 4'b0100, 1'b0, 4'b1111, 0, 4'b0000, 1'b0, 1'b0, 4'b0100});
        vecs.push_back('{32'h2000_0040, 4'b1011, 1'b1, 4'b1111, 0, 4'b0100, 1'b0, 1'b0, 4'b0100});
        vecs.push_back('{32'h0000_0000, 4'b0001, 1'b1, 4'b1111, 0, 4'b0001, 1'b1, 1'b1, 4'b0001});
        vecs.push_back('{32'h1FFF_FFFF, 4'b0010, 1'b1, 4'b1111, 0, 4'b0010, 1'b1, 1'b1, 4'b0010});
        vecs.push_back('{32'h3FFF_FFFF, 4'b1000, 1'b1, 4'b1111, 0, 4'b1000, 1'b1, 1'b1, 4'b1000});
        vecs.push_back('{32'h4000_0000, 4'b1111, 1'b1, 4'b1111, 0, 4'b0000, 1'b1, 1'b0, 4'b0000});
        vecs.push_back('{32'h1000_0000, 4'b1111, 1'b1, 4'b1101, 0, 4'b0000, 1'b1, 1'b0, 4'b0000});
        vecs.push_back('{32'h0800_0000, 4'b1111, 1'b1, 4'b1111, 1, 4'b0001, 1'b1, 1'b1, 4'b0001});
        vecs.push_back('{32'h0800_0000, 4'b1111, 1'b1, 4'b1110, 1, 4'b0010, 1'b1, 1'b1, 4'b0010});

        foreach (vecs[i]) begin
            set_map(vecs[i].ovl);
            conn      = vecs[i].conn;
            awaddr_i  = vecs[i].addr;
            awready_i = vecs[i].rdy;
            grant     = vecs[i].grant;
            awvalid_i = 1'b1;
            #1;
            check($sformatf("vec%0d_awvalid", i), 32'(awvalid_o), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_awready", i), 32'(awready_o), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_push", i), 32'(push_dest_o), 32'(vecs[i].exp_push));
            check($sformatf("vec%0d_dest", i), 32'(dest_o), 32'(vecs[i].exp_dest));
            awvalid_i = 1'b0;
            tick();
        end

        // Three routed bursts outstanding ahead of a miss.
        set_map(1'b0);
        conn      = 4'b1111;
        grant     = 1'b1;
        awaddr_i  = 32'h2000_0040;
        awready_i = 4'b0100;
        awvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("seq3_push", 32'(push_dest_o), 32'd1);
            tick();
        end
        awvalid_i = 1'b0;
        miss_seq("seq3", 32'h5000_0000, 4'h7, 3);

        conn = 4'b1101;
        miss_seq("noconn", 32'h1000_0000, 4'hA, 0);

        // Randomized routing against the region model; outstanding count tracked here.
        conn      = 4'b1111;
        model_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            set_map(1'($urandom_range(0, 1)));
            awaddr_i   = 32'($urandom_range(0, 32'h3FFF_FFFF));
            awready_i  = 4'($urandom_range(0, 15));
            awvalid_i  = 1'($urandom_range(0, 1));
            grant      = (model_cnt < FD) ? 1'($urandom_range(0, 1)) : 1'b0;
            wlast_done = (model_cnt > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            exp_dest = model_dest(awaddr_i);
            exp_rdy  = ((awready_i & exp_dest) != 4'b0000) && grant;
            exp_vld  = (awvalid_i && grant) ? exp_dest : 4'b0000;
            check("rand_dest", 32'(dest_o), 32'(exp_dest));
            check("rand_awvalid", 32'(awvalid_o), 32'(exp_vld));
            check("rand_awready", 32'(awready_o), 32'(exp_rdy));
            check("rand_push", 32'(push_dest_o), 32'(awvalid_i && exp_rdy));
            if (awvalid_i && exp_rdy) model_cnt++;
            if (wlast_done) model_cnt--;
            tick();
        end
        wlast_done = 1'b0;
        awvalid_i  = 1'b0;
        set_map(1'b0);
        miss_seq("rand", 32'h4800_0000, 4'h5, model_cnt);

        // Reset while a DECERR response is pending.
        awaddr_i  = 32'h6000_0000;
        awid_i    = 4'h9;
        awvalid_i = 1'b1;
        tick();
        awvalid_i = 1'b0;
        tick();
        werr_done = 1'b1;
        tick();
        werr_done = 1'b0;
        check("rstb_pre_bvalid", 32'(bvalid_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstb_bvalid", 32'(bvalid_o), 32'd0);
        check("rstb_bresp", 32'(bresp_o), 32'd0);
        check("rstb_bid", 32'(bid_o), 32'd0);
        check("rstb_handle", 32'(handle_error_o), 32'd0);
        awaddr_i  = 32'h0000_0000;
        awready_i = 4'b0001;
        grant     = 1'b1;
        awvalid_i = 1'b1;
        #1;
        check("rstb_awvalid", 32'(awvalid_o), 32'h1);
        check("rstb_awready", 32'(awready_o), 32'd1);
        check("rstb_push", 32'(push_dest_o), 32'd1);
        check("rstb_dest", 32'(dest_o), 32'h1);
        tick();
        awvalid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
